// File: rtl/led_ctrl_pkg.sv
// Shared types and defaults for the status-LED blink-code arbiter.
// The round-robin pick helper lives here so both arbiter builds share one search.
package led_ctrl_pkg;

   localparam int MAX_REQ       = 8;
   localparam int DEF_TICK_DIV  = 1200000;
   localparam int DEF_ON_TICKS  = 2;
   localparam int DEF_OFF_TICKS = 2;
   localparam int DEF_GAP_TICKS = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2,
      GAP  = 2'd3
   } state_t;

   // Index of the first set request after 'last', wrapping within nreq.
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req_v,
                                          input int nreq,
                                          input logic [2:0] last);
      logic [2:0] idx;
      logic       found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         if (k <= nreq) begin
            idx = 3'((int'(last) + k) % nreq);
            if (!found && req_v[idx]) begin
               rr_pick = idx;
               found   = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler for the LED sequencer: counts 0..TICK_DIV-1 and flags the last count.
// A synchronous clear restarts the count so every phase starts tick-aligned.
module led_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int W = $clog2(TICK_DIV);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == W'(TICK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_code_arbiter.sv
// Shares one status LED between NREQ requesters, each playing an N-flash blink code.
// Round-robin arbitration by default; define FIXED_PRIO_EN for lowest-index-wins priority.
//
// state | meaning
// IDLE  | no owner; arbitrate any pending req (zero code completes here in one cycle)
// ON    | LED lit for ON_TICKS ticks of the current flash
// OFF   | LED dark for OFF_TICKS ticks between flashes
// GAP   | LED dark for GAP_TICKS ticks after the last flash, then done
module led_code_arbiter
   import led_ctrl_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int CODE_W    = 4,
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int ON_TICKS  = DEF_ON_TICKS,
   parameter int OFF_TICKS = DEF_OFF_TICKS,
   parameter int GAP_TICKS = DEF_GAP_TICKS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*CODE_W-1:0] code,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        done,
   output logic                   busy,
   output logic                   led
);

   localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ?
                           ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS) :
                           ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   state_t              state_q, state_d;
   logic [NREQ-1:0]     gnt_q, gnt_d, done_q, done_d;
   logic                busy_q, busy_d, led_q, led_d;
   logic [2:0]          rr_q, rr_d, win_q, win_d;
   logic [CODE_W-1:0]   flash_q, flash_d;
   logic [PH_W-1:0]     phase_q, phase_d;

   logic                tick, presc_clr, phase_end, req_w;
   logic [2:0]          pick;
   logic [CODE_W-1:0]   pick_code;
   logic [NREQ-1:0]     pick_oh, win_oh;
   logic [PH_W-1:0]     ph_last;

   always_comb begin
`ifdef FIXED_PRIO_EN
      pick = rr_pick(MAX_REQ'(req), NREQ, 3'(NREQ - 1));
`else
      pick = rr_pick(MAX_REQ'(req), NREQ, rr_q);
`endif
      pick_code = '0;
      pick_oh   = '0;
      win_oh    = '0;
      req_w     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == 3'(i)) begin
            pick_code  = code[i*CODE_W +: CODE_W];
            pick_oh[i] = 1'b1;
         end
         if (win_q == 3'(i)) begin
            win_oh[i] = 1'b1;
            req_w     = req[i];
         end
      end
   end

   always_comb begin
      ph_last = PH_W'(ON_TICKS - 1);
      case (state_q)
         OFF:     ph_last = PH_W'(OFF_TICKS - 1);
         GAP:     ph_last = PH_W'(GAP_TICKS - 1);
         default: ph_last = PH_W'(ON_TICKS - 1);
      endcase
   end

   assign phase_end = tick && (phase_q == ph_last);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      busy_d  = busy_q;
      led_d   = led_q;
      rr_d    = rr_q;
      win_d   = win_q;
      flash_d = flash_q;
      phase_d = phase_q;
      case (state_q)
         IDLE: begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            led_d   = 1'b0;
            phase_d = '0;
            if (|req) begin
               win_d  = pick;
               rr_d   = pick;
               gnt_d  = pick_oh;
               busy_d = 1'b1;
               if (pick_code != '0) begin
                  state_d = ON;
                  led_d   = 1'b1;
                  flash_d = pick_code;
               end else begin
                  done_d = pick_oh;
               end
            end
         end
         default: begin
            // Owner withdrew: drop everything silently, no done.
            if (!req_w) begin
               state_d = IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
               led_d   = 1'b0;
               phase_d = '0;
            end else if (tick) begin
               phase_d = phase_q + 1'b1;
               if (phase_end) begin
                  phase_d = '0;
                  case (state_q)
                     ON: begin
                        flash_d = flash_q - 1'b1;
                        led_d   = 1'b0;
                        state_d = (flash_q != CODE_W'(1)) ? OFF : GAP;
                     end
                     OFF: begin
                        state_d = ON;
                        led_d   = 1'b1;
                     end
                     default: begin
                        state_d = IDLE;
                        done_d  = win_oh;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                     end
                  endcase
               end
            end
         end
      endcase
   end

   assign presc_clr = (state_d != state_q) || (state_q == IDLE);

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (presc_clr),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         led_q   <= 1'b0;
         rr_q    <= '0;
         win_q   <= '0;
         flash_q <= '0;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         led_q   <= led_d;
         rr_q    <= rr_d;
         win_q   <= win_d;
         flash_q <= flash_d;
         phase_q <= phase_d;
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign busy = busy_q;
   assign led  = led_q;

endmodule

// File: tb/tb_led_code_arbiter.sv
// Bench for led_code_arbiter: a cycle-level blink-schedule model checked every cycle,
// plus directed scenarios with hand-computed expectations (FIXED_PRIO_EN selects priority build).
module tb_led_code_arbiter;

   localparam int NREQ = 4, CW = 4, TD = 4, ONT = 2, OFFT = 1, GAPT = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NREQ-1:0] req = '0;
   logic [15:0]     code = '0;
   logic [NREQ-1:0] gnt, done;
   logic            busy, led;

   led_code_arbiter #(
      .NREQ(NREQ), .CODE_W(CW), .TICK_DIV(TD),
      .ON_TICKS(ONT), .OFF_TICKS(OFFT), .GAP_TICKS(GAPT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .code(code),
      .gnt(gnt), .done(done), .busy(busy), .led(led)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int oh_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   // ---------------- schedule model ----------------
   int              m_owner, m_rr, m_pos, m_len, m_code;
   logic            m_led, m_busy, m_zero;
   logic [NREQ-1:0] m_gnt, m_done;

   function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
`ifdef FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
      return -1;
   endfunction

   // LED level 'pos' cycles after the grant edge for a code of c flashes.
   function automatic logic led_at(input int pos, input int c);
      int period = (ONT + OFFT) * TD;
      if (pos / period < c) return (pos % period) < ONT * TD;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = -1; m_rr = 0; m_pos = 0; m_len = 0; m_code = 0;
         m_led = 0; m_busy = 0; m_zero = 0; m_gnt = '0; m_done = '0;
      end else begin
         int w, c;
         m_done = '0;
         m_zero = 1'b0;
         if (m_owner >= 0) begin
            if (!req[m_owner]) begin
               m_owner = -1; m_led = 0; m_gnt = '0; m_busy = 0;
            end else begin
               m_pos++;
               if (m_pos == m_len) begin
                  m_done = '0; m_done[m_owner] = 1'b1;
                  m_owner = -1; m_led = 0; m_gnt = '0; m_busy = 0;
               end else begin
                  m_led = led_at(m_pos, m_code);
               end
            end
         end else begin
            m_gnt = '0; m_busy = 0; m_led = 0;
            if (req != '0) begin
               w = model_pick(req, m_rr);
               c = int'(code[w*CW +: CW]);
               m_rr = w;
               m_gnt[w] = 1'b1;
               m_busy = 1'b1;
               if (c == 0) begin
                  m_done[w] = 1'b1;
                  m_zero = 1'b1;
               end else begin
                  m_owner = w; m_code = c; m_pos = 0; m_led = 1'b1;
                  m_len = c * ONT * TD + (c - 1) * OFFT * TD + GAPT * TD;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_led",  led,  m_led);
         chk("cyc_gnt",  gnt,  m_gnt);
         chk("cyc_done", done, m_done);
         if (!m_zero) chk("cyc_busy", busy, m_busy);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   int led_hi, gnt_hi, done_k, dcnt, n, gaps, first_len, run;
   int order[4];
   logic l7, l8, l12, l19, l20;
   logic [NREQ-1:0] prev;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_led", led, 0);
      rst = 1'b0;
      cmp_en = 1'b1;

      // single request, code 2
      @(negedge clk);
      code = 16'h0002; req = 4'b0001;
      @(negedge clk);
      led_hi = 0; gnt_hi = 0; done_k = -1;
      l7 = 0; l8 = 1; l12 = 0; l19 = 0; l20 = 1;
      for (int k = 0; k < 60; k++) begin
         if (led) led_hi++;
         if (gnt[0]) gnt_hi++;
         if (k == 7) l7 = led;
         if (k == 8) l8 = led;
         if (k == 12) l12 = led;
         if (k == 19) l19 = led;
         if (k == 20) l20 = led;
         if (done[0]) begin
            done_k = k;
            req = '0;
            break;
         end
         @(negedge clk);
      end
      chk("single_led_hi", led_hi, 16);
      chk("single_gnt_hi", gnt_hi, 32);
      chk("single_done_k", done_k, 32);
      chk("single_led7", l7, 1);
      chk("single_led8", l8, 0);
      chk("single_led12", l12, 1);
      chk("single_led19", l19, 1);
      chk("single_led20", l20, 0);

      // zero code
      @(negedge clk);
      code = 16'h0000; req = 4'b0100;
      @(negedge clk);
      chk("zero_gnt", gnt, 4'b0100);
      chk("zero_done", done, 4'b0100);
      chk("zero_led", led, 0);
      req = '0;
      @(negedge clk);
      chk("zero_gnt_after", gnt, 0);
      chk("zero_done_after", done, 0);

      // arbitration order with several requesters held
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      code = 16'h1111; req = 4'b1011;
      n = 0; gaps = 0; first_len = 0; prev = '0;
      for (int k = 0; k < 300 && n < 4; k++) begin
         @(negedge clk);
         if (gnt != '0 && prev == '0) begin
            order[n] = oh_idx(gnt);
            n++;
         end else if (gnt == '0 && n >= 1) begin
            gaps++;
         end
         if (n == 1 && gnt != '0) first_len++;
         prev = gnt;
      end
      chk("arb_grants", n, 4);
`ifdef FIXED_PRIO_EN
      chk("fixed_g0", order[0], 0);
      chk("fixed_g1", order[1], 0);
      chk("fixed_g2", order[2], 0);
      chk("fixed_g3", order[3], 0);
`else
      chk("rr_g0", order[0], 1);
      chk("rr_g1", order[1], 3);
      chk("rr_g2", order[2], 0);
      chk("rr_g3", order[3], 1);
`endif
      chk("arb_seq_len", first_len, 20);
      chk("arb_idle_gaps", gaps, 3);
      req = '0;
      repeat (2) @(negedge clk);

`ifdef FIXED_PRIO_EN
      // req1 vs req3: lowest index keeps winning
      code = 16'h1111; req = 4'b1010;
      n = 0; prev = '0;
      for (int k = 0; k < 200 && n < 3; k++) begin
         @(negedge clk);
         if (gnt != '0 && prev == '0) begin
            order[n] = oh_idx(gnt);
            n++;
         end
         prev = gnt;
      end
      chk("fixed_starve_n", n, 3);
      chk("fixed_starve_a", order[0], 1);
      chk("fixed_starve_b", order[1], 1);
      chk("fixed_starve_c", order[2], 1);
      req = '0;
      repeat (2) @(negedge clk);
`endif

      // abort during ON
      code = 16'h0030; req = 4'b0010;
      repeat (5) @(negedge clk);
      chk("abort_led_before", led, 1);
      chk("abort_gnt_before", gnt, 4'b0010);
      req = '0;
      @(negedge clk);
      chk("abort_led", led, 0);
      chk("abort_gnt", gnt, 0);
      chk("abort_busy", busy, 0);
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done[1]) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);

      // asynchronous reset while lit
      code = 16'h0001; req = 4'b0001;
      repeat (4) @(negedge clk);
      chk("rst_mid_led_before", led, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_led", led, 0);
      chk("rst_mid_gnt", gnt, 0);
      chk("rst_mid_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      run = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (led) break;
      end
      while (led && run < 50) begin
         run++;
         @(negedge clk);
      end
      chk("rst_mid_on_run", run, 8);
      req = '0;
      repeat (3) @(negedge clk);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
